// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check, store lane replication
// with byte strobes, and load byte/half extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            ea_lo,
  input  logic [2:0]            funct3,
  input  logic                  is_store,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fault,
  output logic [3:0]            wstrb,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{ea_lo, 3'b000} +: 8];
  assign rd_half = ea_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    fault     = 1'b0;
    wstrb     = 4'b0000;
    wdata     = store_data;
    load_data = rdata;
    case (funct3)
      F3_B: begin
        wstrb     = 4'b0001 << ea_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
      end
      F3_BU: begin
        fault     = is_store;
        load_data = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
      end
      F3_H: begin
        fault     = ea_lo[0];
        wstrb     = ea_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      end
      F3_HU: begin
        fault     = is_store | ea_lo[0];
        load_data = {{(DATA_WIDTH-16){1'b0}}, rd_half};
      end
      F3_W: begin
        fault = |ea_lo;
        wstrb = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: IDLE -> REQ (handshaked memory access) -> RESP,
// with faulting accesses skipping straight to RESP. Drives the register-file write port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] base_i,
  input  logic [DATA_WIDTH-1:0] offset_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  RegWrite_o,
  output logic [ADDR_WIDTH-1:0] write_addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o
);

  lsu_state_t state, nxt;

  logic [DATA_WIDTH-1:0] ea_in, ea_q, sdata_q, wdata_q;
  logic [ADDR_WIDTH-1:0] rd_q, waddr_q;
  logic [2:0]            funct3_q;
  logic                  is_store_q, fault_q;

  logic                  a_fault;
  logic [3:0]            a_wstrb;
  logic [DATA_WIDTH-1:0] a_wdata, a_load;
  logic [1:0]            a_ea_lo;
  logic [2:0]            a_funct3;
  logic                  a_store;
  logic                  load_wr;

  assign ea_in = base_i + offset_i;

  // One align instance serves both the IDLE legality check (live inputs)
  // and the REQ lane/extract logic (latched request).
  assign a_ea_lo  = (state == IDLE) ? ea_in[1:0] : ea_q[1:0];
  assign a_funct3 = (state == IDLE) ? funct3_i   : funct3_q;
  assign a_store  = (state == IDLE) ? is_store_i : is_store_q;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .ea_lo      (a_ea_lo),
    .funct3     (a_funct3),
    .is_store   (a_store),
    .store_data (sdata_q),
    .rdata      (mem_rdata_i),
    .fault      (a_fault),
    .wstrb      (a_wstrb),
    .wdata      (a_wdata),
    .load_data  (a_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_i) nxt = a_fault ? RESP : REQ;
      REQ:     if (mem_ready_i) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state != IDLE);
    mem_req_o   = (state == REQ);
    mem_we_o    = (state == REQ) & is_store_q;
    mem_wstrb_o = ((state == REQ) & is_store_q) ? a_wstrb : 4'b0000;
    mem_wdata_o = ((state == REQ) & is_store_q) ? a_wdata : '0;
    done_o      = (state == RESP);
    fault_o     = (state == RESP) & fault_q;
    RegWrite_o  = (state == RESP) & ~fault_q & ~is_store_q & (rd_q != '0);
  end

  assign mem_addr_o   = {ea_q[DATA_WIDTH-1:2], 2'b00};
  assign load_wr      = (state == REQ) & mem_ready_i & ~is_store_q & (rd_q != '0);
  assign write_addr_o = waddr_q;
  assign write_data_o = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q       <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        ea_q       <= ea_in;
        sdata_q    <= store_data_i;
        rd_q       <= rd_addr_i;
        funct3_q   <= funct3_i;
        is_store_q <= is_store_i;
        fault_q    <= a_fault;
      end
      // Write-port regs only move on a real register write; otherwise they hold.
      if (load_wr) begin
        waddr_q <= rd_q;
        wdata_q <= a_load;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit: byte-addressed reference
// memory model plus a responding memory with random wait states.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] base_i, offset_i, store_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o, done_o, fault_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        RegWrite_o;
  logic [4:0]  write_addr_o;
  logic [31:0] write_data_o;

  load_store_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .base_i(base_i), .offset_i(offset_i),
    .store_data_i(store_data_i), .rd_addr_i(rd_addr_i), .busy_o(busy_o),
    .done_o(done_o), .fault_o(fault_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .RegWrite_o(RegWrite_o),
    .write_addr_o(write_addr_o), .write_data_o(write_data_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  pmem [0:1023];  // memory as seen/written by the DUT
  logic [7:0]  rmem [0:1023];  // reference memory, byte semantics
  logic [31:0] last_wd;
  logic [4:0]  last_wa;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wstrb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pword(input logic [31:0] a);
    logic [9:0] w;
    w = {a[9:2], 2'b00};
    return {pmem[w+3], pmem[w+2], pmem[w+1], pmem[w]};
  endfunction

  function automatic logic [31:0] rword(input logic [31:0] a);
    logic [9:0] w;
    w = {a[9:2], 2'b00};
    return {rmem[w+3], rmem[w+2], rmem[w+1], rmem[w]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      pmem[10'(a + 32'(i))] = d[8*i +: 8];
      rmem[10'(a + 32'(i))] = d[8*i +: 8];
    end
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                       input int waits, input bit poke);
    logic [31:0] ea, exp_ld;
    int n;
    bit ill, flt, wr;
    ea  = base + off;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    flt = ill || ((ea & 32'(n - 1)) != 0);
    exp_ld = '0;
    for (int i = 0; i < n; i++) exp_ld |= 32'(rmem[10'(ea + 32'(i))]) << (8 * i);
    if (!f3[2] && n < 4 && exp_ld[8*n-1]) exp_ld |= ~((32'h1 << (8 * n)) - 1);
    wr = !flt && !st && (rd != 5'd0);

    @(negedge clk);
    start_i = 1'b1; is_store_i = st; funct3_i = f3; base_i = base; offset_i = off;
    store_data_i = sd; rd_addr_i = rd;
    @(negedge clk);
    start_i = 1'b0;
    is_store_i = 1'($urandom); funct3_i = 3'($urandom); base_i = $urandom;
    offset_i = $urandom; store_data_i = $urandom; rd_addr_i = 5'($urandom);
    if (flt) begin
      chk("fault_done", 32'(done_o), 1);
      chk("fault_flag", 32'(fault_o), 1);
      chk("fault_noreq", 32'(mem_req_o), 0);
      chk("fault_nowr", 32'(RegWrite_o), 0);
    end else begin
      chk("req", 32'(mem_req_o), 1);
      chk("req_done", 32'(done_o), 0);
      chk("req_addr", mem_addr_o, ea & 32'hFFFF_FFFC);
      chk("req_we", 32'(mem_we_o), 32'(st));
      for (int w = 0; w < waits; w++) begin
        start_i = poke && (w == 0);
        if (start_i) begin
          is_store_i = 1'b0; funct3_i = 3'b010; base_i = 32'h0; offset_i = 32'h0;
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("wait_req", 32'(mem_req_o), 1);
        chk("wait_addr", mem_addr_o, ea & 32'hFFFF_FFFC);
      end
      mem_ready_i = 1'b1;
      mem_rdata_i = pword(mem_addr_o);
      obs_wdata = mem_wdata_o;
      obs_wstrb = mem_wstrb_o;
      if (mem_we_o)
        for (int i = 0; i < 4; i++)
          if (mem_wstrb_o[i]) pmem[{mem_addr_o[9:2], 2'(i)}] = mem_wdata_o[8*i +: 8];
      if (st)
        for (int i = 0; i < n; i++) rmem[10'(ea + 32'(i))] = sd[8*i +: 8];
      @(negedge clk);
      mem_ready_i = 1'b0;
      mem_rdata_i = $urandom;
      chk("resp_done", 32'(done_o), 1);
      chk("resp_fault", 32'(fault_o), 0);
      chk("resp_regwrite", 32'(RegWrite_o), 32'(wr));
      if (wr) begin
        last_wd = exp_ld;
        last_wa = rd;
      end
      if (st) chk("store_mem", pword(ea), rword(ea));
    end
    chk("wr_addr", 32'(write_addr_o), 32'(last_wa));
    chk("wr_data", write_data_o, last_wd);
    @(negedge clk);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_regwrite", 32'(RegWrite_o), 0);
    chk("idle_wr_data", write_data_o, last_wd);
  endtask

  initial begin
    rst = 1'b1; start_i = 0; is_store_i = 0; funct3_i = 0; base_i = 0; offset_i = 0;
    store_data_i = 0; rd_addr_i = 0; mem_ready_i = 0; mem_rdata_i = 0;
    last_wd = '0; last_wa = '0;
    for (int i = 0; i < 1024; i++) begin
      pmem[i] = 8'($urandom);
      rmem[i] = pmem[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_wstrb", 32'(mem_wstrb_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", write_data_o, 0);
    rst = 1'b0;

    // LW 0x100+4 with two wait states
    set_word(32'h104, 32'hDEADBEEF);
    do_op(0, 3'b010, 32'h100, 32'h4, 0, 5'd5, 2, 0);
    chk("lw_data", write_data_o, 32'hDEADBEEF);
    chk("lw_addr", 32'(write_addr_o), 5);

    // LB / LBU at 0x103
    set_word(32'h100, 32'h80112233);
    do_op(0, 3'b000, 32'h100, 32'h3, 0, 5'd6, 0, 0);
    chk("lb_data", write_data_o, 32'hFFFFFF80);
    do_op(0, 3'b100, 32'h0F0, 32'h13, 0, 5'd7, 1, 0);
    chk("lbu_data", write_data_o, 32'h00000080);

    // SH at 0x202
    do_op(1, 3'b001, 32'h200, 32'h2, 32'h0000ABCD, 5'd9, 1, 0);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_wstrb", 32'(obs_wstrb), 32'b1100);

    // Faults: misaligned LW, illegal store funct3
    do_op(0, 3'b010, 32'h100, 32'h2, 0, 5'd3, 0, 0);
    do_op(1, 3'b100, 32'h100, 32'h0, 32'h55, 5'd3, 0, 0);

    // rd=0 load with a start pulse during REQ
    do_op(0, 3'b010, 32'h180, 32'h0, 0, 5'd0, 2, 1);

    // Reset in the middle of REQ
    @(negedge clk);
    start_i = 1; is_store_i = 0; funct3_i = 3'b010; base_i = 32'h140; offset_i = 0;
    rd_addr_i = 5'd4;
    @(negedge clk);
    start_i = 0;
    chk("pre_rst_req", 32'(mem_req_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drop_req", 32'(mem_req_o), 0);
    chk("rst_drop_busy", 32'(busy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    last_wd = '0; last_wa = '0;
    set_word(32'h144, 32'h12345678);
    do_op(0, 3'b010, 32'h140, 32'h4, 0, 5'd11, 1, 0);
    chk("post_rst_lw", write_data_o, 32'h12345678);

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      logic [31:0] b, o;
      b = 32'h100 + 32'($urandom_range(0, 511));
      o = 32'($signed(7'($urandom)));
      do_op(1'($urandom), 3'($urandom), b, o, $urandom, 5'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that executes one RV32I memory instruction per request: computes the effective address, drives a ready-handshaked data-memory port with byte strobes, and aligns and extends load data. It sits between the execute stage and data memory, and is the writer into the register file's write port. `RegWrite_o`, `write_addr_o` and `write_data_o` connect directly to that port.

## Interface
- `ADDR_WIDTH`, 5, register address width
- `DATA_WIDTH`, 32, data and memory address width (RV32 only)
- `clk` input 1, rising-edge clock
- `rst` input 1, asynchronous, active-high reset
- `start_i` input 1, request strobe; sampled only in IDLE
- `is_store_i` input 1, 1 = store, 0 = load
- `funct3_i` input 3, size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others are illegal
- `base_i` input DATA_WIDTH, rs1 value
- `offset_i` input DATA_WIDTH, sign-extended immediate
- `store_data_i` input DATA_WIDTH, rs2 value
- `rd_addr_i` input ADDR_WIDTH, load destination
- `busy_o` output 1, high whenever state ≠ IDLE
- `done_o` output 1, one-cycle completion pulse
- `fault_o` output 1, valid with `done_o`; set for a misaligned access or illegal funct3
- `mem_req_o` output 1, memory request
- `mem_we_o` output 1, write enable
- `mem_addr_o` output DATA_WIDTH, word-aligned address (bits [1:0] = 00)
- `mem_wdata_o` output DATA_WIDTH, lane-replicated store data
- `mem_wstrb_o` output 4, byte strobes
- `mem_ready_i` input 1, memory accept/complete
- `mem_rdata_i` input DATA_WIDTH, read data; valid in the cycle `mem_ready_i` is high
- `RegWrite_o` output 1, register-file write enable
- `write_addr_o` output ADDR_WIDTH, register-file write address
- `write_data_o` output DATA_WIDTH, register-file write data

## Operation
- **States:** IDLE, REQ, RESP.
- **IDLE, `start_i`=1:**
  - Latch `ea = base_i + offset_i` (mod 2^32), along with `is_store_i`, `funct3_i`, `store_data_i` and `rd_addr_i`.
  - Go to REQ, or go to RESP with the fault flag set if the access is misaligned (H with `ea[0]`=1, W with `ea[1:0]`≠0) or funct3 is illegal. Store funct3 100/101 is illegal.
- **REQ:**
  - `mem_req_o`=1.
  - Address, we, wdata and wstrb are held stable until `mem_ready_i`=1.
  - On ready: capture `mem_rdata_i`, go to RESP.
- **RESP:** for exactly one cycle:
  - `done_o`=1.
  - `fault_o` = fault flag.
  - For a non-faulting load with `rd`≠0: `RegWrite_o`=1 and `write_data_o` = aligned data.
  - Then return to IDLE.
- **Store lanes:**
  - B: wdata = byte ×4, wstrb = `1 << ea[1:0]`.
  - H: wdata = half ×2, wstrb = 0011 (`ea[1]`=0) or 1100.
  - W: wstrb = 1111.
- **Load extract:**
  - Byte at `ea[1:0]*8`; half at `ea[1]*16`.
  - B/H sign-extend; BU/HU zero-extend.
- **Outputs outside the stated cycles:** `RegWrite_o`, `done_o`, `fault_o`, `mem_req_o` and `mem_we_o` are 0. `write_addr_o` and `write_data_o` hold their last values.
- `start_i` while busy is ignored and not queued.

## Timing
- **Reset values:** all outputs 0, state IDLE. Reset mid-REQ drops `mem_req_o` asynchronously; the in-flight access is abandoned and not retried.
- **Normal access:** `start_i` in cycle N → `mem_req_o` from N+1 → ready in cycle M ≥ N+1 → `done_o` (and `RegWrite_o`) in M+1 → IDLE in M+2. A new `start_i` is accepted in M+2.
- **Zero-wait memory:** ready=1 in N+1 gives completion at N+2. Throughput is 1 op per 3 cycles.
- **Fault:** `start_i` in N → `done_o`=`fault_o`=1 in N+1, with no memory request.
- `mem_ready_i` is ignored outside REQ.
- Write data reaches the register file at the rising edge ending the RESP cycle.

## Structure
- **Package `lsu_pkg`:**
  - `lsu_state_t` enum {IDLE, REQ, RESP}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- **Sub-module `lsu_align`** (combinational): from (`ea[1:0]`, funct3, store data, read data), produce the misaligned/illegal flag, wstrb, wdata and load result.
- The FSM and latches live in `load_store_unit`.

## Test plan
- LW, base=0x100, off=4, memory returns 0xDEADBEEF after 2 wait cycles, rd=5 → addr 0x104, `done_o` 1 cycle after ready, `RegWrite_o`=1, `write_addr_o`=5, data 0xDEADBEEF.
- LB/LBU at ea=0x103, rdata=0x80112233 → LB writes 0xFFFFFF80; LBU writes 0x00000080.
- SH, ea=0x202, `store_data_i`=0x0000ABCD → addr 0x200, wdata 0xABCDABCD, wstrb 1100, `mem_we_o`=1, no `RegWrite_o`.
- LW at ea=0x102 → `done_o`=`fault_o`=1 at N+1, `mem_req_o` never asserted, no `RegWrite_o`; the same fault occurs for store funct3=100.
- LW with rd=0 completes with `RegWrite_o`=0; `start_i` pulsed during REQ is ignored.
- `rst` asserted while in REQ → `mem_req_o` and `busy_o` go to 0 immediately; after release, a new LW completes normally.
